eqn_ckt_vector_checker: RTL and testbench
=========================================

// Module: eqn_ckt_vector_checker
// PURPOSE
//  Drives all 8 input vectors into the Y = A&B | A&C equation circuit and checks each output.
//  On start it walks {A,B,C} = 0..7. Each vector is held for a settle window, then Y is
//  sampled and compared with A&(B|C). At the end it reports done, pass, an error count
//  and the first failing vector. Used as the on-chip exerciser of the equation circuit.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles each vector is held before Y is sampled; legal values >= 1
// PORTS
//  clk               input   1  rising-edge clock
//  rst_n             input   1  asynchronous active-low reset
//  start             input   1  one-cycle request to begin a run; honoured only in IDLE
//  abort             input   1  cancels a run in progress; returns to IDLE, no done pulse
//  Y                 input   1  output of the circuit under test
//  A                 output  1  drive to the circuit under test, = vec[2]
//  B                 output  1  drive to the circuit under test, = vec[1]
//  C                 output  1  drive to the circuit under test, = vec[0]
//  busy              output  1  high while in DRIVE or SAMPLE
//  done              output  1  one-cycle pulse when a run completes
//  pass              output  1  1 when the last completed run had zero errors; held until next start
//  err_count         output  4  number of mismatching vectors, range 0..8
//  first_fail_valid  output  1  at least one mismatch recorded in this run
//  first_fail_vec    output  3  {A,B,C} of the first mismatch; valid when first_fail_valid=1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, vec=0, A=B=C=0, busy=0, done=0, pass=0,
//   err_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
//  States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered.
//  IDLE:
//   - start=1 -> DRIVE, vec=0, settle counter=0.
//   - On that transition: clear err_count, pass, first_fail_valid, first_fail_vec.
//  DRIVE: A,B,C=vec. Stays for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
//  SAMPLE: one cycle, with A,B,C still held.
//   - Compare Y to exp = A&(B|C).
//   - On mismatch: err_count += 1. If first_fail_valid=0, latch first_fail_vec=vec and set
//     first_fail_valid=1.
//   - Next state: if vec==7 -> DONE; else vec += 1 -> DRIVE.
//  DONE: one cycle.
//   - done=1; pass=(err_count==0), where err_count includes any vec-7 mismatch.
//   - A,B,C return to 0; next state is IDLE.
//  Latency: vector k is held for cycles k*(S+1)+1 .. k*(S+1)+S+1 after the start edge, where
//   S = SETTLE_CYCLES. done rises in cycle 8*(S+1)+1; this is 25 for S=2.
//  start while busy or in DONE: ignored, with no effect on the run in progress.
//  abort:
//   - In DRIVE or SAMPLE: next state IDLE, A=B=C=0, pass=0, no done pulse.
//   - err_count and first_fail_* keep their partial values.
//   - abort overrides the SAMPLE comparison in the same cycle.
//   - In IDLE or DONE: abort is ignored.
//  start and abort together in IDLE: start wins; abort applies only to an active run.
//  Arithmetic: vec is 3 bits and never wraps, because SAMPLE at vec 7 exits.
//   err_count is 4 bits, max value 8, no saturation needed.
//  Y is treated as synchronous to clk; the settle window covers the combinational delay.
// TESTING
//  T1 reset: assert rst_n=0 mid-DRIVE -> all outputs take their reset values immediately.
//   After rst_n=1, IDLE holds with A=B=C=0.
//  T2 correct circuit, S=2: start at cycle 0.
//   -> A,B,C step 000..111 every 3 cycles; done=1 in cycle 25.
//   -> pass=1, err_count=0, first_fail_valid=0.
//  T3 faulty model Y=A&B -> mismatch only at vec 5.
//   -> err_count=1, first_fail_vec=3'b101, pass=0.
//  T4 Y stuck at 1 -> mismatches at vec 0..4.
//   -> err_count=5, first_fail_vec=3'b000, pass=0.
//  T5 abort in DRIVE of vec 3 -> next cycle IDLE, A=B=C=0, no done.
//   Then start again -> full run completes, done in cycle 25, pass=1.
//  T6 start pulsed during SAMPLE of vec 2 -> ignored; run finishes unchanged at cycle 25.
//   start together with abort in IDLE -> run begins.

Source files
------------

// File: rtl/eqn_ckt_vector_checker.sv
// Exerciser for the Y = A&B | A&C circuit: walks all 8 input vectors,
// samples Y after a settle window and reports pass, error count and first failure.
module eqn_ckt_vector_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       first_fail_valid,
    output logic [2:0] first_fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      vec_q;
    logic [2:0]      vec_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      abc_q;
    logic [2:0]      abc_d;
    logic            busy_d;
    logic            done_d;
    logic            pass_d;
    logic [3:0]      err_d;
    logic            ffv_d;
    logic [2:0]      ffvec_d;
    logic            active;
    logic            expected;
    logic            mismatch;

    assign active   = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign expected = abc_q[2] & (abc_q[1] | abc_q[0]);
    assign mismatch = (Y != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (abort)                  state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)              state_d = ST_IDLE;
                else if (vec_q == 3'd7) state_d = ST_DONE;
                else                    state_d = ST_DRIVE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of every registered output; abort suppresses the compare.
    always_comb begin
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass;
        err_d   = err_count;
        ffv_d   = first_fail_valid;
        ffvec_d = first_fail_vec;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d   = 3'd0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    ffv_d   = 1'b0;
                    ffvec_d = 3'd0;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    pass_d = 1'b0;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                cnt_d = '0;
                if (abort) begin
                    pass_d = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_d = err_count + 4'd1;
                        if (!first_fail_valid) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    if (vec_q != 3'd7) vec_d = vec_q + 3'd1;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        if (state_d == ST_DONE) pass_d = (err_d == 4'd0);
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        abc_d  = busy_d ? vec_d : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q            <= 3'd0;
            cnt_q            <= '0;
            abc_q            <= 3'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 4'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 3'd0;
        end else begin
            vec_q            <= vec_d;
            cnt_q            <= cnt_d;
            abc_q            <= abc_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail_valid <= ffv_d;
            first_fail_vec   <= ffvec_d;
        end
    end

    assign A = abc_q[2];
    assign B = abc_q[1];
    assign C = abc_q[0];

endmodule

// File: tb/tb_eqn_ckt_vector_checker.sv
// Bench for eqn_ckt_vector_checker: the circuit under test is a truth table
// driven by the bench; expected results come from comparing it to A&(B|C).
module tb_eqn_ckt_vector_checker;

    localparam int S = 2;
    localparam int P = S + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic       ffv;
    logic [2:0] ffvec;
    logic [7:0] tt = 8'hE0;

    int n_checks = 0;
    int n_pass = 0;

    assign y = tt[{a, b, c}];

    always #5 clk = ~clk;

    eqn_ckt_vector_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .Y(y),
        .A(a),
        .B(b),
        .C(c),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_fail_valid(ffv),
        .first_fail_vec(ffvec)
    );

    // One run: start, optional abort cycle, optional stray start cycle (0 = none).
    task automatic do_run(input logic [7:0] t, input int abort_cyc,
                          input int start_cyc, input string nm);
        int         exp_err;
        logic       exp_ffv;
        logic [2:0] exp_ffvec;
        logic [2:0] kv;
        logic       g;
        logic       exp_pass;
        int         last;
        tt = t;
        exp_err = 0;
        exp_ffv = 1'b0;
        exp_ffvec = 3'd0;
        for (int k = 0; k < 8; k++) begin
            kv = 3'(k);
            g = kv[2] & (kv[1] | kv[0]);
            if (abort_cyc == 0 || P * (k + 1) < abort_cyc) begin
                if (t[k] != g) begin
                    exp_err++;
                    if (!exp_ffv) begin
                        exp_ffv = 1'b1;
                        exp_ffvec = kv;
                    end
                end
            end
        end
        exp_pass = (abort_cyc == 0) && (exp_err == 0);
        last = (abort_cyc != 0) ? abort_cyc + 1 : 8 * P + 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= last; n++) begin
            if (n < last) begin
                n_checks++;
                if ({a, b, c} !== 3'((n - 1) / P)) begin
                    $display("FAIL %s abc cyc%0d: got %b want %b", nm, n,
                             {a, b, c}, 3'((n - 1) / P));
                end else n_pass++;
                n_checks++;
                if ({busy, done, pass} !== 3'b100) begin
                    $display("FAIL %s busy/done/pass cyc%0d: got %b want 100",
                             nm, n, {busy, done, pass});
                end else n_pass++;
                abort = (n == abort_cyc);
                start = (n == start_cyc);
            end else begin
                abort = 1'b0;
                start = 1'b0;
                n_checks++;
                if ({a, b, c, busy} !== 4'b0000) begin
                    $display("FAIL %s end abc/busy: got %b want 0000", nm,
                             {a, b, c, busy});
                end else n_pass++;
                n_checks++;
                if (done !== (abort_cyc == 0)) begin
                    $display("FAIL %s end done: got %b want %b", nm, done,
                             abort_cyc == 0);
                end else n_pass++;
                n_checks++;
                if (pass !== exp_pass) begin
                    $display("FAIL %s pass: got %b want %b", nm, pass, exp_pass);
                end else n_pass++;
                n_checks++;
                if (err_count !== 4'(exp_err)) begin
                    $display("FAIL %s err_count: got %0d want %0d", nm,
                             err_count, exp_err);
                end else n_pass++;
                n_checks++;
                if ({ffv, ffvec} !== {exp_ffv, exp_ffvec}) begin
                    $display("FAIL %s first_fail: got %b/%b want %b/%b", nm,
                             ffv, ffvec, exp_ffv, exp_ffvec);
                end else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({done, busy, pass} !== {2'b00, exp_pass}) begin
            $display("FAIL %s after: done/busy/pass got %b want 00%b", nm,
                     {done, busy, pass}, exp_pass);
        end else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({a, b, c, busy, done, pass, err_count, ffv, ffvec} !== 15'd0) begin
            $display("FAIL reset_init: got %b want 0",
                     {a, b, c, busy, done, pass, err_count, ffv, ffvec});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tt = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a, b, c, busy} !== 4'b0011) begin
            $display("FAIL reset_pre: abc/busy got %b want 0011", {a, b, c, busy});
        end else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a, b, c, busy, done, pass, err_count, ffv, ffvec} !== 15'd0) begin
            $display("FAIL reset_async: got %b want 0",
                     {a, b, c, busy, done, pass, err_count, ffv, ffvec});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({a, b, c, busy, done} !== 5'd0) begin
                $display("FAIL reset_idle: got %b want 00000", {a, b, c, busy, done});
            end else n_pass++;
        end
    endtask

    task automatic test_correct();
        do_run(8'hE0, 0, 0, "correct");
    endtask

    task automatic test_fault_and();
        do_run(8'hC0, 0, 0, "y_ab");
    endtask

    task automatic test_stuck_one();
        do_run(8'hFF, 0, 0, "stuck1");
    endtask

    task automatic test_abort();
        do_run(8'hFF, 3 * P + 1, 0, "abort_v3");
        do_run(8'hE0, 0, 0, "after_abort");
        do_run(8'h1F, 2 * P + 3, 0, "abort_sample");
    endtask

    task automatic test_start_ignored();
        do_run(8'hE0, 0, 2 * P + 3, "start_busy");
    endtask

    task automatic test_start_abort_idle();
        int t_done;
        tt = 8'hE0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL start_abort_idle busy: got %b want 1", busy);
        end else n_pass++;
        t_done = 0;
        for (int n = 1; n <= 40 && t_done == 0; n++) begin
            if (done === 1'b1) t_done = n;
            else @(negedge clk);
        end
        n_checks++;
        if (t_done != 8 * P + 1 || pass !== 1'b1) begin
            $display("FAIL start_abort_idle done: cyc %0d pass %b want cyc %0d pass 1",
                     t_done, pass, 8 * P + 1);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] t;
        int ac;
        int sc;
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom_range(0, 255));
            ac = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8 * P) : 0;
            sc = $urandom_range(1, (ac != 0) ? ac : 8 * P);
            do_run(t, ac, sc, "random");
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_fault_and();
        test_stuck_one();
        test_abort();
        test_start_ignored();
        test_start_abort_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
